// File: rtl/flash_store.sv
// flash_store: behavioural flash responder with multi-cycle program timing.
// Tracks the highest programmed address and reports busy/done/error pulses.
module flash_store #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 256,
  parameter int PROG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_write,
  input  logic [ADDR_W-1:0] add_flash,
  input  logic [DATA_W-1:0] write_data_flash,
  output logic [DATA_W-1:0] data_flash,
  output logic [ADDR_W-1:0] max_address,
  output logic              empty,
  output logic              busy,
  output logic              wr_done,
  output logic              wr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PROG_CYCLES - 1);

  typedef enum logic {IDLE, PROG} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_max;
  logic              r_empty;
  logic              r_busy;
  logic              r_wr_done;
  logic              r_wr_err;

  logic              w_in_range;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_rd_data;

  // Out-of-range and never-programmed entries both read as erased.
  assign w_in_range = ({1'b0, add_flash} < DEPTH_C);
  assign w_rd_idx   = add_flash[IDX_W-1:0];
  assign w_wr_idx   = r_addr[IDX_W-1:0];
  assign w_rd_data  = (w_in_range && r_valid[w_rd_idx])
                      ? r_mem[w_rd_idx] : '1;

  // Program FSM, storage array, read port and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '1;
      r_valid   <= '0;
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= '1;
      r_cnt     <= '0;
      r_rd      <= '1;
      r_max     <= '0;
      r_empty   <= 1'b1;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_rd <= w_rd_data;
          if (flash_write) begin
            if (w_in_range) begin
              r_addr  <= add_flash;
              r_data  <= write_data_flash;
              r_cnt   <= CNT_INIT;
              r_busy  <= 1'b1;
              r_state <= PROG;
            end else begin
              r_wr_err <= 1'b1;
            end
          end
        end
        PROG: begin
          // Requests during a program are rejected, not queued.
          if (flash_write) r_wr_err <= 1'b1;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_mem[w_wr_idx]   <= r_data;
            r_valid[w_wr_idx] <= 1'b1;
            if (r_empty || (r_addr > r_max)) r_max <= r_addr;
            r_empty   <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
      endcase
    end
  end

  assign data_flash  = r_rd;
  assign max_address = r_max;
  assign empty       = r_empty;
  assign busy        = r_busy;
  assign wr_done     = r_wr_done;
  assign wr_err      = r_wr_err;

endmodule
